// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - access size, extension and FSM state encodings for data_mem_access_unit
package mem_if_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_WAIT_R = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane replication, byte enables, load lane select and extension
module mem_lane_align
  import mem_if_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        ext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    rdata_o = 32'h0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{ext_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{ext_i & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// rtl/data_mem_access_unit.sv - byte/half/word load-store to word req/gnt/rvalid bus; MISALIGN_TRAP_EN enables misalign traps
module data_mem_access_unit
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        data_size,
  input  logic              ext_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              ext_q, ext_d;
  logic              load_q, load_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic        accept, access, misalign, idle;
  logic [1:0]  off_in;
  logic [1:0]  al_size, al_off;
  logic        al_ext;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign idle   = (state_q == ST_IDLE);
  assign accept = req_valid & idle;
  assign access = (mem_read | mem_write) & (data_size != SZ_NONE);

`ifdef MISALIGN_TRAP_EN
  assign misalign = access & (((data_size == SZ_HALF) & addr[0]) |
                              ((data_size == SZ_WORD) & (addr[1:0] != 2'b00)));
  assign off_in   = addr[1:0];
`else
  assign misalign = 1'b0;
  assign off_in   = (data_size == SZ_WORD) ? 2'b00 :
                    (data_size == SZ_HALF) ? {addr[1], 1'b0} : addr[1:0];
`endif

  // One aligner serves both directions: live inputs while idle (store lanes), latched controls afterwards (load data).
  assign al_size = idle ? data_size : size_q;
  assign al_off  = idle ? off_in    : off_q;
  assign al_ext  = idle ? ext_type  : ext_q;

  mem_lane_align u_align (
    .size_i  (al_size),
    .off_i   (al_off),
    .ext_i   (al_ext),
    .wdata_i (wdata),
    .rdata_i (mem_rdata),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    off_d       = off_q;
    ext_d       = ext_q;
    load_d      = load_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          size_d = data_size;
          off_d  = off_in;
          ext_d  = ext_type;
          load_d = ~mem_write;
          if (!access || misalign) begin
            rsp_rdata_d = 32'h0;
            state_d     = ST_DONE;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = mem_write;
            mem_be_d    = al_be;
            mem_addr_d  = addr[ADDR_W-1:2];
            mem_wdata_d = al_wdata;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (load_q) begin
            state_d = ST_WAIT_R;
          end else begin
            rsp_rdata_d = 32'h0;
            state_d     = ST_DONE;
          end
        end
      end
      ST_WAIT_R: begin
        if (mem_rvalid) begin
          rsp_rdata_d = al_rdata;
          state_d     = ST_DONE;
        end
      end
      default: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      size_q      <= SZ_NONE;
      off_q       <= 2'b00;
      ext_q       <= EXT_ZERO;
      load_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      off_q       <= off_d;
      ext_q       <= ext_d;
      load_q      <= load_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err_q <= 1'b0;
    end else if (accept) begin
      rsp_err_q <= misalign;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = idle;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb/tb_data_mem_access_unit.sv - directed and randomized self-checking bench for data_mem_access_unit
module tb_data_mem_access_unit;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              mem_read = 1'b0;
  logic              mem_write = 1'b0;
  logic [1:0]        data_size = 2'b00;
  logic              ext_type = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [31:0]       mem_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .data_size  (data_size),
    .ext_type   (ext_type),
    .addr       (addr),
    .wdata      (wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd3) ? 4 : int'(sz);
  endfunction

  function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
    int nb;
    nb = nbytes(sz);
    return (int'(a[1:0]) / nb) * nb;
  endfunction

  function automatic bit is_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (sz != 2'd0) && ((int'(a[1:0]) % nbytes(sz)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic ext,
                                           input logic [31:0] a, input logic [31:0] rd);
    int nb;
    logic [31:0] v, m;
    nb = nbytes(sz);
    v  = rd >> (8 * lane_off(sz, a));
    if (nb < 4) begin
      m = (32'h1 << (8 * nb)) - 32'h1;
      v = v & m;
      if (ext && v[8*nb-1]) v = v | ~m;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] be;
    int off, nb;
    off = lane_off(sz, a);
    nb  = nbytes(sz);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nb);
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int nb;
    nb = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  task automatic do_access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                           input logic ext, input logic [31:0] a, input logic [31:0] wd,
                           input int gd, input int rdly, input logic [31:0] rdat);
    int lat, exp_lat;
    bit act, ld, mis;
    logic [31:0] exp_rd;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    act = (rd || wr) && (sz != 2'd0);
    ld  = !wr;
    mis = act && is_misaligned(sz, a);
    exp_rd = 32'h0;
    @(negedge clk);
    check({tag, ".ready_idle"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; data_size = sz;
    ext_type = ext; addr = a; wdata = wd;
    @(negedge clk);
    lat = 0;
    req_valid = 1'b0; mem_read = $urandom_range(1); mem_write = $urandom_range(1);
    data_size = 2'($urandom); ext_type = $urandom_range(1); addr = $urandom; wdata = $urandom;
    if (act && !mis) begin
      ebe = ref_be(sz, a);
      ewd = ref_wdata(sz, wd);
      for (int k = 0; k <= gd; k++) begin
        check({tag, ".req"}, {31'h0, mem_req}, 32'h1);
        check({tag, ".we"}, {31'h0, mem_we}, {31'h0, wr});
        check({tag, ".be"}, {28'h0, mem_be}, {28'h0, ebe});
        check({tag, ".addr"}, {2'b00, mem_addr}, a >> 2);
        if (wr) check({tag, ".wdata"}, mem_wdata, ewd);
        check({tag, ".ready_busy"}, {31'h0, req_ready}, 32'h0);
        if (k < gd) begin
          @(negedge clk); lat++;
        end
      end
      mem_gnt = 1'b1;
      @(negedge clk); lat++;
      mem_gnt = 1'b0;
      check({tag, ".req_drop"}, {31'h0, mem_req}, 32'h0);
      if (ld) begin
        repeat (rdly) begin
          @(negedge clk); lat++;
        end
        mem_rdata = rdat; mem_rvalid = 1'b1;
        @(negedge clk); lat++;
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        exp_rd  = ref_load(sz, ext, a, rdat);
        exp_lat = 3 + gd + rdly;
      end else begin
        exp_lat = 2 + gd;
      end
    end else begin
      check({tag, ".no_req"}, {31'h0, mem_req}, 32'h0);
      exp_lat = 1;
    end
    while (!rsp_valid && lat < 64) begin
      @(negedge clk); lat++;
    end
    check({tag, ".rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".rdata"}, rsp_rdata, exp_rd);
    check({tag, ".err"}, {31'h0, rsp_err}, {31'h0, mis});
    @(negedge clk);
    check({tag, ".rsp_pulse"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst.ready", {31'h0, req_ready}, 32'h1);
    check("rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst.rsp_rdata", rsp_rdata, 32'h0);
    check("rst.rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst.mem_req", {31'h0, mem_req}, 32'h0);
    check("rst.mem_we", {31'h0, mem_we}, 32'h0);
    check("rst.mem_be", {28'h0, mem_be}, 32'h0);
    check("rst.mem_addr", {2'b00, mem_addr}, 32'h0);
    check("rst.mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    do_access("sw", 1'b0, 1'b1, 2'd3, 1'b0, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0);
    do_access("sb", 1'b0, 1'b1, 2'd1, 1'b0, 32'h13, 32'h000000A5, 0, 0, 32'h0);
    do_access("lb_s", 1'b1, 1'b0, 2'd1, 1'b1, 32'h21, 32'h0, 0, 0, 32'h123480FF);
    do_access("lb_z", 1'b1, 1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 0, 0, 32'h123480FF);
    do_access("lh_s", 1'b1, 1'b0, 2'd2, 1'b1, 32'h22, 32'h0, 0, 0, 32'h7ABC0000);
    do_access("lw_slow", 1'b1, 1'b0, 2'd3, 1'b0, 32'h48, 32'h0, 3, 2, 32'hCAFEF00D);
    do_access("sh_slow", 1'b0, 1'b1, 2'd2, 1'b0, 32'h1E, 32'h1234ABCD, 3, 0, 32'h0);
    do_access("none", 1'b0, 1'b0, 2'd3, 1'b0, 32'h30, 32'h0, 0, 0, 32'h0);
    do_access("sz0", 1'b1, 1'b0, 2'd0, 1'b1, 32'h30, 32'h0, 0, 0, 32'h0);
    do_access("lw_mis", 1'b1, 1'b0, 2'd3, 1'b0, 32'h6, 32'h0, 0, 0, 32'h89ABCDEF);

    // Abandon a load in WAIT_R; the late rvalid must not produce a response.
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; data_size = 2'd3; addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA; mem_gnt = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("rst_mid.rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("rst_mid.mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_mid.ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
    end
    do_access("lw_after_rst", 1'b1, 1'b0, 2'd3, 1'b1, 32'h44, 32'h0, 0, 0, 32'h80000001);

    for (int i = 0; i < 40; i++) begin
      logic rd, wr;
      rd = $urandom_range(1);
      wr = $urandom_range(1);
      do_access($sformatf("rnd%0d", i), rd, wr, 2'($urandom), 1'($urandom), $urandom & 32'hFFFF,
                $urandom, $urandom_range(3), $urandom_range(3), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
